// File: rtl/iqmod_pkg.sv
// Shared constants for the IQ modulator: register map, mode encodings,
// DAC control word and register reset values.
package iqmod_pkg;

  localparam logic [2:0] AddrCenter = 3'd0;
  localparam logic [2:0] AddrModInc = 3'd1;
  localparam logic [2:0] AddrDev    = 3'd2;
  localparam logic [2:0] AddrMode   = 3'd3;
  localparam logic [2:0] AddrStep   = 3'd4;
  localparam logic [2:0] AddrSpan   = 3'd5;
  localparam logic [2:0] AddrStatus = 3'd6;
  localparam logic [2:0] AddrCommit = 3'd7;

  typedef enum logic [1:0] {
    ModeCw    = 2'd0,
    ModeFm    = 2'd1,
    ModeSweep = 2'd2,
    ModeRsvd  = 2'd3
  } mode_e;

  // {pd, dacen, ide, ren_b, g[3:0], 2'b00}
  localparam logic [9:0] DacCtrlWord = 10'b0100100000;

  localparam int unsigned StartWait   = 3;
  localparam int unsigned StartSettle = 5;

  localparam logic [31:0] RstCenter = 32'd59652324;
  localparam logic [31:0] RstModInc = 32'd596523;
  localparam logic [31:0] RstDev    = 32'd250;
  localparam mode_e       RstMode   = ModeFm;

endpackage

// File: rtl/dds.sv
// Phase-accumulator DDS with sine and quadrature (cosine) outputs; the waveform
// is a per-half-cycle parabola, odd-symmetric so the two halves mirror exactly.
module dds #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned PHASE_W = 12,
  parameter int unsigned SINE_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ACC_W-2:0]         inc,
  output logic signed [SINE_W-1:0] sine,
  output logic signed [SINE_W-1:0] cosine
);

  localparam int unsigned HalfW = PHASE_W - 1;
  localparam int unsigned ProdW = 2 * HalfW;
  localparam int unsigned Shift = 2 * (PHASE_W - 2) - (SINE_W - 1);
  localparam logic [ProdW-1:0] AmpMax = ProdW'((2 ** (SINE_W - 1)) - 1);
  localparam logic [PHASE_W-1:0] Quarter = PHASE_W'(2 ** (PHASE_W - 2));

  function automatic logic signed [SINE_W-1:0] wave(input logic [PHASE_W-1:0] p);
    logic [ProdW-1:0] xe, ye, amp;
    logic signed [SINE_W-1:0] mag;
    xe  = ProdW'(p[HalfW-1:0]);
    ye  = (ProdW'(1) << HalfW) - xe;
    amp = (xe * ye) >> Shift;
    if (amp > AmpMax) amp = AmpMax;
    mag = $signed(amp[SINE_W-1:0]);
    return p[PHASE_W-1] ? -mag : mag;
  endfunction

  logic [ACC_W-1:0]   acc_q;
  logic [PHASE_W-1:0] phase;

  assign phase = acc_q[ACC_W-1 -: PHASE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      sine   <= '0;
      cosine <= '0;
    end else begin
      acc_q  <= acc_q + {1'b0, inc};
      sine   <= wave(phase);
      cosine <= wave(phase + Quarter);
    end
  end

endmodule

// File: rtl/iqmod_startup_seq.sv
// Power-up sequencer: waits, strobes the DAC control word, lets it settle,
// then releases the datapath into RUN.
module iqmod_startup_seq
  import iqmod_pkg::*;
#(
  parameter int unsigned CW_HOLD = 7
) (
  input  logic clk,
  input  logic rst_n,
  output logic cw_b,
  output logic mux_sel,
  output logic run
);

  localparam logic [1:0] StWait   = 2'd0;
  localparam logic [1:0] StCtrl   = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StRun    = 2'd3;

  localparam logic [7:0] WaitLast   = 8'(StartWait - 1);
  localparam logic [7:0] CtrlLast   = 8'(CW_HOLD - 1);
  localparam logic [7:0] SettleLast = 8'(StartSettle - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    case (state_q)
      StWait: begin
        if (cnt_q == WaitLast) begin
          state_d = StCtrl;
          cnt_d   = '0;
        end
      end
      StCtrl: begin
        if (cnt_q == CtrlLast) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWait;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cw_b    = (state_q != StCtrl);
  assign mux_sel = (state_q == StCtrl) || (state_q == StSettle);
  assign run     = (state_q == StRun);

endmodule

// File: rtl/multimode_modulator_wb_slave.sv
// Wishbone-controlled IQ modulator (CW / FM / optional sweep) with shadow/active
// registers and explicit commit. Optional sweep built when IQMOD_SWEEP_EN is defined.
module multimode_modulator_wb_slave
  import iqmod_pkg::*;
#(
  parameter int unsigned SINE_W  = 16,
  parameter int unsigned PHASE_W = 12,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned DAC_W   = 10,
  parameter int unsigned DEV_W   = 17,
  parameter int unsigned CW_HOLD = 7
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [2:0]       i_wb_addr,
  input  logic [31:0]      i_wb_data,
  output logic             o_wb_ack,
  output logic             o_wb_stall,
  output logic [31:0]      o_wb_data,
  output logic [DAC_W-1:0] o_dac_a,
  output logic [DAC_W-1:0] o_dac_b,
  output logic             o_cw_b
);

  localparam int unsigned IW = ACC_W - 1;
  localparam int unsigned PW = DEV_W + SINE_W;
  localparam logic signed [PW-1:0] SatHi = PW'({(IW - 1){1'b1}});
  localparam logic signed [PW-1:0] SatLo = -SatHi;
  localparam logic [DAC_W-1:0] DacMid = {1'b1, {(DAC_W - 1){1'b0}}};

  logic cw_b, mux_sel, run;

  iqmod_startup_seq #(.CW_HOLD(CW_HOLD)) u_startup (
    .clk    (i_clk),
    .rst_n  (i_reset_n),
    .cw_b   (cw_b),
    .mux_sel(mux_sel),
    .run    (run)
  );

  logic xfer, wr, rd, commit;
  assign xfer   = i_wb_stb & run;
  assign wr     = xfer & i_wb_we;
  assign rd     = xfer & ~i_wb_we;
  assign commit = wr && (i_wb_addr == AddrCommit);

  logic [IW-1:0]           sh_center, sh_mod_inc, act_center, act_mod_inc;
  logic signed [DEV_W-1:0] sh_dev, act_dev;
  mode_e                   sh_mode, act_mode;
  logic                    pending_q, ack_q, sticky_q;
  logic [31:0]             rdata_q, rd_mux;

`ifdef IQMOD_SWEEP_EN
  logic [IW-1:0] sh_step, sh_span, act_step, act_span, sweep_acc_q;
  logic [IW:0]   sweep_sum;
  logic          sweep_wrap;
  assign sweep_sum  = {1'b0, sweep_acc_q} + {1'b0, act_step};
  assign sweep_wrap = sweep_sum > {1'b0, act_span};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sh_step     <= '0;
      sh_span     <= '0;
      act_step    <= '0;
      act_span    <= '0;
      sweep_acc_q <= '0;
      sticky_q    <= 1'b0;
    end else begin
      if (wr && i_wb_addr == AddrStep) sh_step <= i_wb_data[IW-1:0];
      if (wr && i_wb_addr == AddrSpan) sh_span <= i_wb_data[IW-1:0];
      if (commit) begin
        act_step    <= sh_step;
        act_span    <= sh_span;
        sweep_acc_q <= '0;
      end else if (run && act_mode == ModeSweep) begin
        sweep_acc_q <= sweep_wrap ? '0 : sweep_sum[IW-1:0];
      end
      // A wrap in the same cycle as a STATUS read wins so no event is lost.
      if (run && !commit && act_mode == ModeSweep && sweep_wrap) sticky_q <= 1'b1;
      else if (rd && i_wb_addr == AddrStatus) sticky_q <= 1'b0;
    end
  end
`else
  assign sticky_q = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sh_center   <= IW'(RstCenter);
      sh_mod_inc  <= IW'(RstModInc);
      sh_dev      <= DEV_W'(RstDev);
      sh_mode     <= RstMode;
      act_center  <= IW'(RstCenter);
      act_mod_inc <= IW'(RstModInc);
      act_dev     <= DEV_W'(RstDev);
      act_mode    <= RstMode;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ack_q   <= xfer;
      rdata_q <= rd ? rd_mux : '0;
      if (wr) begin
        case (i_wb_addr)
          AddrCenter: begin sh_center  <= i_wb_data[IW-1:0];       pending_q <= 1'b1; end
          AddrModInc: begin sh_mod_inc <= i_wb_data[IW-1:0];       pending_q <= 1'b1; end
          AddrDev:    begin sh_dev     <= i_wb_data[DEV_W-1:0];    pending_q <= 1'b1; end
          AddrMode:   begin sh_mode    <= mode_e'(i_wb_data[1:0]); pending_q <= 1'b1; end
`ifdef IQMOD_SWEEP_EN
          AddrStep, AddrSpan: pending_q <= 1'b1;
`endif
          default: ;
        endcase
      end
      if (commit) begin
        act_center  <= sh_center;
        act_mod_inc <= sh_mod_inc;
        act_dev     <= sh_dev;
        act_mode    <= sh_mode;
        pending_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (i_wb_addr)
      AddrCenter: rd_mux = 32'(sh_center);
      AddrModInc: rd_mux = 32'(sh_mod_inc);
      AddrDev:    rd_mux = 32'(sh_dev);
      AddrMode:   rd_mux = 32'(sh_mode);
`ifdef IQMOD_SWEEP_EN
      AddrStep:   rd_mux = 32'(sh_step);
      AddrSpan:   rd_mux = 32'(sh_span);
`endif
      AddrStatus: rd_mux = {29'b0, pending_q, run, sticky_q};
      default:    rd_mux = '0;
    endcase
  end

  logic signed [SINE_W-1:0] mod_sin, mod_cos, carrier_sin, carrier_cos;
  logic signed [PW-1:0]     prod;
  logic signed [IW-1:0]     fm_off, off_d, offset_q;
  logic [IW-1:0]            carrier_inc_q;

  always_comb begin
    prod = act_dev * mod_sin;
    if (prod > SatHi)      fm_off = SatHi[IW-1:0];
    else if (prod < SatLo) fm_off = SatLo[IW-1:0];
    else                   fm_off = prod[IW-1:0];
    off_d = '0;
    if (act_mode == ModeFm) off_d = fm_off;
`ifdef IQMOD_SWEEP_EN
    if (act_mode == ModeSweep && act_span != '0) off_d = sweep_acc_q;
`endif
  end

  logic [DAC_W-1:0] dac_a_q, dac_b_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      offset_q      <= '0;
      carrier_inc_q <= IW'(RstCenter);
      dac_a_q       <= DacMid;
      dac_b_q       <= DacMid;
    end else begin
      offset_q      <= off_d;
      carrier_inc_q <= act_center + $unsigned(offset_q);
      // Offset-binary: flip the sign bit and keep the top DAC_W bits.
      dac_a_q <= {~carrier_sin[SINE_W-1], carrier_sin[SINE_W-2 -: DAC_W-1]};
      dac_b_q <= {~carrier_cos[SINE_W-1], carrier_cos[SINE_W-2 -: DAC_W-1]};
    end
  end

  dds #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .SINE_W(SINE_W)) u_dds_mod (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .inc   (act_mod_inc),
    .sine  (mod_sin),
    .cosine(mod_cos)
  );

  dds #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .SINE_W(SINE_W)) u_dds_carrier (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .inc   (carrier_inc_q),
    .sine  (carrier_sin),
    .cosine(carrier_cos)
  );

  logic unused_bits;
  assign unused_bits = ^{i_wb_cyc, i_wb_data[31], mod_cos,
                         carrier_sin[SINE_W-DAC_W-1:0], carrier_cos[SINE_W-DAC_W-1:0]};

  assign o_wb_ack   = ack_q;
  assign o_wb_stall = ~run;
  assign o_wb_data  = rdata_q;
  assign o_cw_b     = cw_b;
  assign o_dac_a    = mux_sel ? DAC_W'(DacCtrlWord) : (run ? dac_a_q : DacMid);
  assign o_dac_b    = run ? dac_b_q : DacMid;

endmodule

// File: tb/tb_multimode_modulator_wb_slave.sv
// Directed bench for multimode_modulator_wb_slave: startup, register map,
// commit, CW quadrature, FM saturation, sweep (or its absence) and async reset.
module tb_multimode_modulator_wb_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, we = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        ack, stall, cw_b;
  logic [31:0] rdata;
  logic [9:0]  dac_a, dac_b;

  always #5 clk = ~clk;

  multimode_modulator_wb_slave dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_wb_cyc  (stb),
    .i_wb_stb  (stb),
    .i_wb_we   (we),
    .i_wb_addr (addr),
    .i_wb_data (wdata),
    .o_wb_ack  (ack),
    .o_wb_stall(stall),
    .o_wb_data (rdata),
    .o_dac_a   (dac_a),
    .o_dac_b   (dac_b),
    .o_cw_b    (cw_b)
  );

  int n_vec = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    check_eq("wr_ack", 64'(ack), 64'd1);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    stb = 1'b0;
    check_eq("rd_ack", 64'(ack), 64'd1);
    d = rdata;
  endtask

  task automatic wait_run(input string tag);
    int edges = 0;
    while (stall && edges < 100) begin
      @(posedge clk); #1; edges++;
    end
    check_eq(tag, 64'(stall), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_stall"}, 64'(stall), 64'd1);
    check_eq({tag, "_cwb"},   64'(cw_b), 64'd1);
    check_eq({tag, "_daca"},  64'(dac_a), 64'd512);
    check_eq({tag, "_dacb"},  64'(dac_b), 64'd512);
    check_eq({tag, "_ack"},   64'(ack), 64'd0);
    check_eq({tag, "_data"},  64'(rdata), 64'd0);
  endtask

  logic [31:0] rv;
  logic [9:0]  da[10], db[10];
  logic signed [30:0] off_s[10];
  logic [30:0] ci_s[10], exp_ci;
  int edges, cw_low, bad_word, early_ack, omax, omin, amax, amin;
  int sat;

  initial begin
    sat = (1 << 30) - 1;

    // Startup sequence with stb held high throughout.
    stb = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1 check_reset_outputs("rel");
    edges = 0; cw_low = 0; bad_word = 0; early_ack = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      edges++;
      if (!cw_b) begin
        cw_low++;
        if (dac_a != 10'b0100100000) bad_word++;
      end
      if (ack) early_ack++;
      if (!stall) break;
    end
    stb = 1'b0;
    check_eq("stall_clks", 64'(edges), 64'd15);
    check_eq("cwb_low_clks", 64'(cw_low), 64'd7);
    check_eq("ctrl_word", 64'(bad_word), 64'd0);
    check_eq("no_ack_in_startup", 64'(early_ack), 64'd0);

    // Reset values of the register map.
    wb_read(3'd0, rv); check_eq("rst_center", 64'(rv), 64'd59652324);
    wb_read(3'd1, rv); check_eq("rst_modinc", 64'(rv), 64'd596523);
    wb_read(3'd2, rv); check_eq("rst_dev", 64'(rv), 64'd250);
    wb_read(3'd3, rv); check_eq("rst_mode", 64'(rv), 64'd1);
    wb_read(3'd6, rv); check_eq("rst_status", 64'(rv), 64'd2);
    wb_read(3'd7, rv); check_eq("commit_reads0", 64'(rv), 64'd0);

    // Shadow write is visible on readback but not active until commit.
    wb_write(3'd0, 32'd1000);
    wb_read(3'd0, rv); check_eq("sh_center", 64'(rv), 64'd1000);
    check_eq("act_center_held", 64'(dut.act_center), 64'd59652324);
    wb_read(3'd6, rv); check_eq("status_pending", 64'(rv), 64'd6);
    wb_write(3'd6, 32'hffff_ffff);
    wb_read(3'd6, rv); check_eq("status_ro", 64'(rv), 64'd6);
    wb_write(3'd7, 32'd0);
    check_eq("act_center_commit", 64'(dut.act_center), 64'd1000);
    wb_read(3'd6, rv); check_eq("status_committed", 64'(rv), 64'd2);

    // CW at a quarter of the clock rate: quadrature and odd symmetry on the DAC.
    wb_write(3'd0, 32'h4000_0000);
    wb_write(3'd3, 32'd0);
    wb_write(3'd7, 32'd0);
    repeat (8) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      da[i] = dac_a; db[i] = dac_b;
      check_eq("cw_offset", 64'(dut.offset_q), 64'd0);
      check_eq("cw_inc", 64'(dut.carrier_inc_q), 64'h4000_0000);
    end
    amax = 0; amin = 1023;
    for (int i = 0; i < 9; i++) check_eq("quad_a_lags_b", 64'(da[i+1]), 64'(db[i]));
    for (int i = 0; i < 8; i++) begin
      check_eq("half_turn", 64'((32'(da[i]) + 32'(da[i+2])) inside {32'd1023, 32'd1024}), 64'd1);
      if (int'(da[i]) > amax) amax = int'(da[i]);
      if (int'(da[i]) < amin) amin = int'(da[i]);
    end
    check_eq("swing", 64'((amax - amin) > 600), 64'd1);

    // FM with maximal deviation: offset clips symmetrically, carrier_inc = CENTER + offset.
    wb_write(3'd2, 32'd65535);
    wb_read(3'd2, rv); check_eq("dev_rb", 64'(rv), 64'd65535);
    wb_write(3'd1, 32'h4000_0000);
    wb_write(3'd3, 32'd1);
    wb_write(3'd7, 32'd0);
    repeat (6) @(posedge clk);
    omax = 0; omin = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      off_s[i] = dut.offset_q; ci_s[i] = dut.carrier_inc_q;
      if (int'(off_s[i]) > omax) omax = int'(off_s[i]);
      if (int'(off_s[i]) < omin) omin = int'(off_s[i]);
    end
    for (int i = 1; i < 10; i++) begin
      exp_ci = 31'h4000_0000 + off_s[i-1];
      check_eq("fm_inc", 64'(ci_s[i]), 64'(exp_ci));
    end
    check_eq("sat_pos", 64'(omax), 64'(sat));
    check_eq("sat_neg", 64'(omin), 64'(-sat));

`ifdef IQMOD_SWEEP_EN
    // Sweep: offset ramps 0,10,20,30 then wraps; sticky set then cleared by read.
    wb_write(3'd4, 32'd10);
    wb_write(3'd5, 32'd35);
    wb_read(3'd4, rv); check_eq("step_rb", 64'(rv), 64'd10);
    wb_read(3'd5, rv); check_eq("span_rb", 64'(rv), 64'd35);
    wb_write(3'd3, 32'd2);
    wb_write(3'd7, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check_eq("sweep_offset", 64'(dut.offset_q), 64'(10 * (i % 4)));
    end
    wb_write(3'd3, 32'd0);
    wb_write(3'd7, 32'd0);
    wb_read(3'd6, rv); check_eq("sticky_set", 64'(rv), 64'd3);
    wb_read(3'd6, rv); check_eq("sticky_clr", 64'(rv), 64'd2);
    wb_write(3'd5, 32'd0);
    wb_write(3'd3, 32'd2);
    wb_write(3'd7, 32'd0);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("span0_offset", 64'(dut.offset_q), 64'd0);
    end
    wb_write(3'd5, 32'd35);
    wb_write(3'd7, 32'd0);
`else
    // Sweep not built: registers 4/5 read 0, MODE=2 acts as CW, sticky reads 0.
    wb_write(3'd4, 32'd10);
    wb_write(3'd5, 32'd35);
    wb_read(3'd4, rv); check_eq("step_absent", 64'(rv), 64'd0);
    wb_read(3'd5, rv); check_eq("span_absent", 64'(rv), 64'd0);
    wb_write(3'd3, 32'd2);
    wb_write(3'd7, 32'd0);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("mode2_offset", 64'(dut.offset_q), 64'd0);
      check_eq("mode2_inc", 64'(dut.carrier_inc_q), 64'h4000_0000);
    end
    wb_read(3'd6, rv); check_eq("status_nosticky", 64'(rv), 64'd2);
`endif

    // Asynchronous reset while an ack is out and a write is on the bus.
    @(negedge clk);
    stb = 1'b1; we = 1'b0; addr = 3'd0;
    @(negedge clk);
    check_eq("pre_rst_ack", 64'(ack), 64'd1);
    we = 1'b1; wdata = 32'd777;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    repeat (2) @(negedge clk);
    stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    wait_run("restart");
    wb_read(3'd0, rv); check_eq("post_rst_center", 64'(rv), 64'd59652324);
    wb_read(3'd3, rv); check_eq("post_rst_mode", 64'(rv), 64'd1);
    wb_read(3'd6, rv); check_eq("post_rst_status", 64'(rv), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
